lab01_3_resp_monitor: RTL

//  Receive-side companion to the lab01_3 stimulus path: captures the 3-bit DUT

---
 rtl/lab01_3_resp_monitor.sv | 133 +++++++++++++
 1 files changed

// File: rtl/lab01_3_resp_monitor.sv
// Response monitor for the lab01_3 stimulus path: samples o a fixed settle time
// after each new vector, checks it, keeps a capture buffer and an 8-bit MISR signature.
module lab01_3_resp_monitor #(
    parameter int unsigned NUM_VEC  = 7,
    parameter int unsigned SETTLE   = 2,
    parameter logic [7:0]  SIG_SEED = 8'hFF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       vec_valid,
    input  logic [2:0] o,
    input  logic [2:0] exp,
    input  logic       exp_en,
    output logic       vec_ack,
    output logic       busy,
    output logic       done,
    output logic [3:0] num_vec,
    output logic [3:0] err_cnt,
    output logic [7:0] sig,
    input  logic [3:0] rd_addr,
    output logic [2:0] rd_data
);

    localparam logic [3:0] NUM_VEC_L   = 4'(NUM_VEC);
    localparam logic [3:0] SETTLE_INIT = (SETTLE == 0) ? 4'd0 : 4'(SETTLE - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_VEC,
        ST_SETTLE,
        ST_SAMPLE,
        ST_ACK,
        ST_DONE
    } state_t;

    state_t     state_q;
    logic [3:0] cnt_q;
    logic       vv_q;
    logic       vec_ack_q;
    logic       busy_q;
    logic       done_q;
    logic [3:0] num_vec_q;
    logic [3:0] err_cnt_q;
    logic [7:0] sig_q;
    logic [2:0] buf_q [16];

    logic       vv_rise;
    logic [7:0] sig_d;
    logic [3:0] err_cnt_d;

    function automatic logic [7:0] misr_step(input logic [7:0] s, input logic [2:0] din);
        logic fb;
        fb = s[7] ^ s[5] ^ s[4] ^ s[3];
        return {s[6:0], fb} ^ {5'b0, din};
    endfunction

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    assign vv_rise   = vec_valid & ~vv_q;
    assign sig_d     = misr_step(sig_q, o);
    assign err_cnt_d = (exp_en && (o != exp)) ? sat_inc(err_cnt_q) : err_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 4'd0;
            vv_q      <= 1'b0;
            vec_ack_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            num_vec_q <= 4'd0;
            err_cnt_q <= 4'd0;
            sig_q     <= 8'h00;
            for (int i = 0; i < 16; i++) buf_q[i] <= 3'b000;
        end else begin
            vv_q      <= vec_valid;
            vec_ack_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    // The capture buffer is deliberately left intact across runs.
                    if (start) begin
                        num_vec_q <= 4'd0;
                        err_cnt_q <= 4'd0;
                        sig_q     <= SIG_SEED;
                        busy_q    <= 1'b1;
                        done_q    <= 1'b0;
                        state_q   <= ST_WAIT_VEC;
                    end
                end
                ST_WAIT_VEC: begin
                    if (vv_rise) begin
                        cnt_q   <= SETTLE_INIT;
                        state_q <= (SETTLE == 0) ? ST_SAMPLE : ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (cnt_q == 4'd0) state_q <= ST_SAMPLE;
                    else               cnt_q   <= cnt_q - 4'd1;
                end
                ST_SAMPLE: begin
                    buf_q[num_vec_q] <= o;
                    sig_q            <= sig_d;
                    err_cnt_q        <= err_cnt_d;
                    num_vec_q        <= num_vec_q + 4'd1;
                    vec_ack_q        <= 1'b1;
                    state_q          <= ST_ACK;
                end
                ST_ACK: begin
                    if (num_vec_q == NUM_VEC_L) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        state_q <= ST_WAIT_VEC;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign vec_ack = vec_ack_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign num_vec = num_vec_q;
    assign err_cnt = err_cnt_q;
    assign sig     = sig_q;
    assign rd_data = (rd_addr < NUM_VEC_L) ? buf_q[rd_addr] : 3'b000;

endmodule
